// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one split-handshake memory bus between fetch and data ports.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ready,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ready,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t              state_q;
  logic                last_q, own_q, req_q, wr_q, iready_q, dready_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, irdata_q, drdata_q;
  logic                inst_el, data_el, grant, gd;
  // a requester still holding req during its ready pulse is not re-granted
  always_comb begin
    inst_el = inst_req & ~iready_q;
    data_el = data_req & ~dready_q;
    grant   = inst_el | data_el;
    gd      = data_el & (~inst_el | ~last_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      own_q    <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      wstrb_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
    end else begin
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      case (state_q)
        IDLE: if (grant) begin
          state_q <= ADDR;
          req_q   <= 1'b1;
          own_q   <= gd;
          last_q  <= gd;
          wr_q    <= gd & data_wr;
          wstrb_q <= gd ? data_wstrb : '0;
          addr_q  <= gd ? data_addr : inst_addr;
          wdata_q <= gd ? data_wdata : '0;
        end
        ADDR: if (mem_addr_ok) begin
          state_q <= DATA;
          req_q   <= 1'b0;
        end
        DATA: if (mem_data_ok) begin
          state_q  <= IDLE;
          iready_q <= ~own_q;
          dready_q <= own_q;
          if (!own_q) irdata_q <= mem_rdata;
          if (own_q && !wr_q) drdata_q <= mem_rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign inst_rdata = irdata_q;
  assign inst_ready = iready_q;
  assign data_rdata = drdata_q;
  assign data_ready = dready_q;
  assign mem_req    = req_q;
  assign mem_wr     = wr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, bus timing, completion and reset.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_req = 1'b0, inst_ready, data_req = 1'b0, data_wr = 1'b0, data_ready;
  logic [31:0] inst_addr = '0, inst_rdata, data_addr = '0, data_wdata = '0, data_rdata;
  logic [3:0]  data_wstrb = '0, mem_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  int n_cmp = 0, n_err = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_wr"}, mem_wr, 0);
    chk({tag, "_wstrb"}, mem_wstrb, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_irdy"}, inst_ready, 0);
    chk({tag, "_drdy"}, data_ready, 0);
    chk({tag, "_irdata"}, inst_rdata, 0);
    chk({tag, "_drdata"}, data_rdata, 0);
  endtask

  // entered in the first mem_req cycle; returns in the ready-pulse cycle
  task automatic run_bus(input string tag, input logic [31:0] a, input int aw, input int dw,
                         input logic [31:0] rd);
    for (int i = 0; i < aw; i++) begin
      chk({tag, "_wreq"}, mem_req, 1);
      chk({tag, "_waddr"}, mem_addr, a);
      step();
    end
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, a);
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    for (int i = 0; i < dw; i++) begin
      chk({tag, "_dreq"}, mem_req, 0);
      chk({tag, "_daddr"}, mem_addr, a);
      chk({tag, "_drdy"}, {inst_ready, data_ready}, 0);
      step();
    end
    chk({tag, "_req0"}, mem_req, 0);
    mem_data_ok = 1'b1;
    mem_rdata = rd;
    step();
    mem_data_ok = 1'b0;
    mem_rdata = 32'h5A5A_A5A5;
  endtask

  initial begin
    step();
    step();
    chk_idle_outs("reset");
    rst = 1'b0;
    data_wstrb = 4'hF;
    // single fetch at minimum latency
    inst_req = 1'b1;
    inst_addr = 32'hBFC0_0000;
    step();
    chk("f_wr", mem_wr, 0);
    chk("f_wstrb", mem_wstrb, 0);
    run_bus("f", 32'hBFC0_0000, 0, 0, 32'h3C08_0001);
    chk("f_irdy", inst_ready, 1);
    chk("f_drdy", data_ready, 0);
    chk("f_irdata", inst_rdata, 32'h3C08_0001);
    inst_req = 1'b0;
    step();
    chk("f_irdy_end", inst_ready, 0);
    chk("f_req_end", mem_req, 0);
    chk("f_irdata_hold", inst_rdata, 32'h3C08_0001);
    // store
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0010;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
    step();
    chk("s_wr", mem_wr, 1);
    chk("s_wstrb", mem_wstrb, 4'b0011);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    run_bus("s", 32'h8000_0010, 0, 0, 32'h1234_5678);
    chk("s_drdy", data_ready, 1);
    chk("s_irdy", inst_ready, 0);
    chk("s_drdata", data_rdata, 0);
    data_req = 1'b0; data_wr = 1'b0;
    step();
    chk("s_drdy_end", data_ready, 0);
    chk("s_irdata_hold", inst_rdata, 32'h3C08_0001);
    // contention from reset: DATA, INST, DATA, INST
    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_addr = 32'h0000_0200; data_wdata = 32'h1111_2222;
    step();
    rst = 1'b0;
    step();
    run_bus("c1", 32'h0000_0200, 0, 0, 32'hD000_0001);
    chk("c1_drdy", {inst_ready, data_ready}, 2'b01);
    chk("c1_drdata", data_rdata, 32'hD000_0001);
    step();
    chk("c2_wr", mem_wr, 0);
    run_bus("c2", 32'h0000_0100, 0, 0, 32'h1000_0002);
    chk("c2_irdy", {inst_ready, data_ready}, 2'b10);
    chk("c2_irdata", inst_rdata, 32'h1000_0002);
    step();
    run_bus("c3", 32'h0000_0200, 0, 0, 32'hD000_0003);
    chk("c3_drdy", {inst_ready, data_ready}, 2'b01);
    step();
    run_bus("c4", 32'h0000_0100, 0, 0, 32'h1000_0004);
    chk("c4_irdy", {inst_ready, data_ready}, 2'b10);
    chk("c4_rdata", {inst_rdata, data_rdata}, {32'h1000_0004, 32'hD000_0003});
    inst_req = 1'b0; data_req = 1'b0;
    step();
    chk("c_idle", mem_req, 0);
    // wait states: mem_req high exactly 4 cycles, one ready pulse
    data_req = 1'b1; data_addr = 32'h0000_0300;
    step();
    inst_req = 1'b1; inst_addr = 32'h0000_0400;
    run_bus("w", 32'h0000_0300, 3, 5, 32'hCAFE_F00D);
    chk("w_drdy", {inst_ready, data_ready}, 2'b01);
    chk("w_drdata", data_rdata, 32'hCAFE_F00D);
    data_req = 1'b0;
    step();
    chk("w_drdy_end", data_ready, 0);
    chk("w_next", mem_addr, 32'h0000_0400);
    // held req masking: inst holds req through its ready, then drops it
    run_bus("h", 32'h0000_0400, 0, 0, 32'h0BAD_CAFE);
    chk("h_irdy", inst_ready, 1);
    step();
    inst_req = 1'b0;
    chk("h_nodup1", mem_req, 0);
    chk("h_irdy_end", inst_ready, 0);
    step();
    chk("h_nodup2", mem_req, 0);
    // reset while in DATA, then a fresh load
    data_req = 1'b1; data_addr = 32'h0000_0500;
    step();
    mem_addr_ok = 1'b1;
    step();
    mem_addr_ok = 1'b0;
    data_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outs("rst_data");
    step();
    chk("rst_stay", mem_req, 0);
    data_req = 1'b1; data_addr = 32'h0000_0004;
    step();
    run_bus("r", 32'h0000_0004, 0, 0, 32'h7777_8888);
    chk("r_drdy", data_ready, 1);
    chk("r_drdata", data_rdata, 32'h7777_8888);
    data_req = 1'b0;
    step();
    chk("r_end", {mem_req, data_ready}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
